// File: rtl/coeff_token_encoder.sv
// CAVLC coeff_token encoder: looks up the coeff_token VLC for (TotalCoeff, TrailingOnes, nC)
// and packs the codewords MSB-first into 16-bit words under valid/ready flow control.
module coeff_token_encoder #(
    parameter int OUT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       TotalCoeff,
    input  logic [1:0]       TrailingOnes,
    input  logic [4:0]       nC,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] OutWord,
    output logic [4:0]       OutBits,
    output logic             OutLast,
    output logic             FlushDone,
    output logic             Error
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int SUM_W = CNT_W + 1;

    // Tables indexed by {TotalCoeff, TrailingOnes}; impossible entries hold 0.
    localparam int T0_LEN [68] = '{
        1, 0, 0, 0,    6, 2, 0, 0,    8, 6, 3, 0,    9, 8, 7, 5,    10, 9, 8, 6,
        11, 10, 9, 7,  13, 11, 10, 8, 13, 13, 11, 9, 13, 13, 13, 10,
        14, 14, 13, 11, 14, 14, 14, 13, 15, 15, 14, 14, 15, 15, 15, 14,
        16, 15, 15, 15, 16, 16, 16, 15, 16, 16, 16, 16, 16, 16, 16, 16
    };
    localparam int T0_CODE [68] = '{
        1, 0, 0, 0,    5, 1, 0, 0,    7, 4, 1, 0,    7, 6, 5, 3,    7, 6, 5, 3,
        7, 6, 5, 4,    15, 6, 5, 4,   11, 14, 5, 4,  8, 10, 13, 4,
        15, 14, 9, 4,  11, 10, 13, 12, 15, 14, 9, 12, 11, 10, 13, 8,
        15, 1, 9, 12,  11, 14, 13, 8, 7, 10, 9, 12,  4, 6, 5, 8
    };
    localparam int T1_LEN [68] = '{
        2, 0, 0, 0,    6, 2, 0, 0,    6, 5, 3, 0,    7, 6, 6, 4,    8, 6, 6, 4,
        8, 7, 7, 5,    9, 8, 8, 6,    11, 9, 9, 6,   11, 11, 11, 7,
        12, 11, 11, 9, 12, 12, 12, 11, 12, 12, 12, 11, 13, 13, 13, 12,
        13, 13, 13, 13, 13, 14, 13, 13, 14, 14, 14, 13, 14, 14, 14, 14
    };
    localparam int T1_CODE [68] = '{
        3, 0, 0, 0,    11, 2, 0, 0,   7, 7, 3, 0,    7, 10, 9, 5,   7, 6, 5, 4,
        4, 6, 5, 6,    7, 6, 5, 8,    15, 6, 5, 4,   11, 14, 13, 4,
        15, 10, 9, 4,  11, 14, 13, 12, 8, 10, 9, 8,  15, 14, 13, 12,
        11, 10, 9, 12, 7, 11, 6, 8,   9, 8, 10, 1,   7, 6, 5, 4
    };
    localparam int T2_LEN [68] = '{
        4, 0, 0, 0,    6, 4, 0, 0,    6, 5, 4, 0,    6, 5, 5, 4,    7, 5, 5, 4,
        7, 5, 5, 4,    7, 6, 6, 4,    7, 6, 6, 4,    8, 7, 7, 5,
        8, 8, 7, 6,    9, 8, 8, 7,    9, 9, 8, 8,    9, 9, 9, 8,
        10, 9, 9, 9,   10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10
    };
    localparam int T2_CODE [68] = '{
        15, 0, 0, 0,   15, 14, 0, 0,  11, 15, 13, 0, 8, 12, 14, 12, 15, 10, 11, 11,
        11, 8, 9, 10,  9, 14, 13, 9,  8, 10, 9, 8,   15, 14, 13, 13,
        11, 14, 10, 12, 15, 10, 13, 12, 11, 14, 9, 12, 8, 10, 13, 8,
        13, 7, 9, 12,  9, 12, 11, 10, 5, 8, 7, 6,    1, 4, 3, 2
    };
    localparam int CDC1_LEN [20] = '{
        2, 0, 0, 0,    6, 1, 0, 0,    6, 6, 3, 0,    6, 7, 7, 6,    6, 8, 8, 7
    };
    localparam int CDC1_CODE [20] = '{
        1, 0, 0, 0,    7, 1, 0, 0,    4, 6, 1, 0,    3, 3, 2, 5,    2, 3, 2, 0
    };
    localparam int CDC2_LEN [36] = '{
        1, 0, 0, 0,    7, 2, 0, 0,    7, 7, 3, 0,    9, 7, 7, 5,    9, 9, 7, 6,
        10, 10, 9, 7,  11, 11, 10, 7, 12, 12, 11, 10, 13, 12, 12, 11
    };
    localparam int CDC2_CODE [36] = '{
        1, 0, 0, 0,    15, 1, 0, 0,   14, 13, 1, 0,  7, 12, 11, 1,  6, 5, 10, 1,
        7, 6, 4, 9,    7, 6, 5, 8,    7, 6, 5, 4,    7, 5, 4, 4
    };

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_PAD,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              s1_full_q, s1_full_d;
    logic [15:0]       s1_code_q, s1_code_d;
    logic [4:0]        s1_len_q, s1_len_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              error_q, error_d;
    logic              out_last_q, out_last_d;
    logic              flush_done_q, flush_done_d;

    logic              illegal;
    logic [6:0]        tok_idx;
    logic [4:0]        tc_m1;
    logic [15:0]       lut_code;
    logic [4:0]        lut_len;

    logic              emit;
    logic              s1_drain;
    logic              accept;
    logic [CNT_W-1:0]  cnt_post;
    logic [ACC_W-1:0]  acc_post;
    logic [SUM_W-1:0]  fill_sum;
    logic [CNT_W-1:0]  app_shift;
    logic [ACC_W-1:0]  code_ext;
    logic [OUT_W-1:0]  pad_mask;

    // Token validation and table lookup; illegal tokens index entry 0 so no read goes out of range.
    always_comb begin
        illegal = (TotalCoeff > 5'd16)
               || ({3'b000, TrailingOnes} > TotalCoeff)
               || ((nC == 5'd31) && (TotalCoeff > 5'd4))
               || ((nC == 5'd30) && (TotalCoeff > 5'd8))
               || ((nC >= 5'd17) && (nC <= 5'd29));
        tok_idx  = illegal ? 7'd0 : {TotalCoeff, TrailingOnes};
        tc_m1    = TotalCoeff - 5'd1;
        lut_code = '0;
        lut_len  = '0;
        if (nC == 5'd31) begin
            lut_code = 16'(CDC1_CODE[tok_idx[4:0]]);
            lut_len  = 5'(CDC1_LEN[tok_idx[4:0]]);
        end else if (nC == 5'd30) begin
            lut_code = 16'(CDC2_CODE[tok_idx[5:0]]);
            lut_len  = 5'(CDC2_LEN[tok_idx[5:0]]);
        end else if (nC <= 5'd1) begin
            lut_code = 16'(T0_CODE[tok_idx]);
            lut_len  = 5'(T0_LEN[tok_idx]);
        end else if (nC <= 5'd3) begin
            lut_code = 16'(T1_CODE[tok_idx]);
            lut_len  = 5'(T1_LEN[tok_idx]);
        end else if (nC <= 5'd7) begin
            lut_code = 16'(T2_CODE[tok_idx]);
            lut_len  = 5'(T2_LEN[tok_idx]);
        end else begin
            lut_len  = 5'd6;
            lut_code = (TotalCoeff == 5'd0) ? 16'h0003 : {10'd0, tc_m1[3:0], TrailingOnes};
        end
    end

    always_comb begin
        OutValid  = (state_q == ST_PAD) || (acc_cnt_q >= CNT_W'(OUT_W));
        emit      = OutValid && OutReady && (state_q != ST_PAD);
        cnt_post  = emit ? (acc_cnt_q - CNT_W'(OUT_W)) : acc_cnt_q;
        acc_post  = emit ? (acc_q << OUT_W) : acc_q;
        fill_sum  = {1'b0, cnt_post} + SUM_W'(s1_len_q);
        s1_drain  = s1_full_q && (fill_sum <= SUM_W'(ACC_W));
        InReady   = (state_q == ST_RUN) && (!s1_full_q || s1_drain);
        accept    = InValid && InReady;
        app_shift = CNT_W'(ACC_W) - cnt_post - CNT_W'(s1_len_q);
        code_ext  = {{(ACC_W-16){1'b0}}, s1_code_q};

        // Append lands just below the bits that survive this cycle's emission.
        acc_d     = acc_post;
        acc_cnt_d = cnt_post;
        if (s1_drain) begin
            acc_d     = acc_post | (code_ext << app_shift);
            acc_cnt_d = cnt_post + CNT_W'(s1_len_q);
        end

        s1_full_d = s1_full_q && !s1_drain;
        s1_code_d = s1_code_q;
        s1_len_d  = s1_len_q;
        error_d   = error_q;
        if (accept) begin
            if (illegal) begin
                error_d = 1'b1;
            end else begin
                s1_full_d = 1'b1;
                s1_code_d = lut_code;
                s1_len_d  = lut_len;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (Flush) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!s1_full_q && (acc_cnt_q < CNT_W'(OUT_W)))
                    state_d = (acc_cnt_q != '0) ? ST_PAD : ST_DONE;
            end
            ST_PAD: begin
                if (OutReady) begin
                    state_d   = ST_DONE;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end
            end
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
        out_last_d   = (state_d == ST_PAD);
        flush_done_d = (state_d == ST_DONE);

        pad_mask = ~({OUT_W{1'b1}} >> acc_cnt_q);
        OutWord  = acc_q[ACC_W-1 -: OUT_W];
        if (state_q == ST_PAD) begin
            OutWord = OutWord & pad_mask;
            OutBits = acc_cnt_q[4:0];
        end else begin
            OutBits = OutValid ? 5'(OUT_W) : 5'd0;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_INIT;
            s1_full_q    <= 1'b0;
            s1_code_q    <= '0;
            s1_len_q     <= '0;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            error_q      <= 1'b0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_full_q    <= s1_full_d;
            s1_code_q    <= s1_code_d;
            s1_len_q     <= s1_len_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            error_q      <= error_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign OutLast   = out_last_q;
    assign FlushDone = flush_done_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_coeff_token_encoder.sv
// Directed bench for coeff_token_encoder: hand-computed codewords and packed words,
// backpressure, flush padding, illegal tokens and mid-operation reset.
module tb_coeff_token_encoder;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [4:0]  nC;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutWord;
    logic [4:0]  OutBits;
    logic        OutLast;
    logic        FlushDone;
    logic        Error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    int last_word_cyc = 0;
    logic [21:0] got_q[$];

    coeff_token_encoder dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .InValid      (InValid),
        .InReady      (InReady),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .nC           (nC),
        .Flush        (Flush),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutWord      (OutWord),
        .OutBits      (OutBits),
        .OutLast      (OutLast),
        .FlushDone    (FlushDone),
        .Error        (Error)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Records every output handshake and FlushDone pulse just before the rising edge.
    always @(negedge Clk) begin
        #4;
        if (nReset && OutValid && OutReady) begin
            got_q.push_back({OutLast, OutBits, OutWord});
            if (OutLast) last_word_cyc <= cyc;
        end
        if (FlushDone) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] nc, input logic [4:0] tc, input logic [1:0] t1,
                        input logic with_flush);
        logic ok;
        ok = 1'b0;
        InValid      = 1'b1;
        nC           = nc;
        TotalCoeff   = tc;
        TrailingOnes = t1;
        Flush        = with_flush;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            ok = InReady;
            @(negedge Clk);
        end
        InValid = 1'b0;
        Flush   = 1'b0;
        check("send accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] w, input logic [4:0] b,
                               input logic l);
        logic [21:0] rec;
        for (int n = 0; n < 200 && got_q.size() == 0; n++) @(negedge Clk);
        check({tag, " present"}, {31'd0, got_q.size() != 0}, 32'd1);
        if (got_q.size() != 0) begin
            rec = got_q.pop_front();
            check({tag, " word"}, {16'd0, rec[15:0]}, {16'd0, w});
            check({tag, " bits"}, {27'd0, rec[20:16]}, {27'd0, b});
            check({tag, " last"}, {31'd0, rec[21]}, {31'd0, l});
        end
    endtask

    task automatic wait_done(input string tag, input int exp_count);
        for (int n = 0; n < 200 && done_count < exp_count; n++) @(negedge Clk);
        check({tag, " flush done"}, done_count, exp_count);
    endtask

    task automatic expect_no_words(input string tag);
        repeat (4) @(negedge Clk);
        check({tag, " no extra words"}, got_q.size(), 0);
    endtask

    initial begin
        InValid      = 1'b0;
        TotalCoeff   = '0;
        TrailingOnes = '0;
        nC           = '0;
        Flush        = 1'b0;
        OutReady     = 1'b1;
        nReset       = 1'b1;
        #1 nReset = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check("reset InReady", {31'd0, InReady}, 32'd0);
        check("reset OutValid", {31'd0, OutValid}, 32'd0);
        check("reset OutWord", {16'd0, OutWord}, 32'd0);
        check("reset OutBits", {27'd0, OutBits}, 32'd0);
        check("reset OutLast", {31'd0, OutLast}, 32'd0);
        check("reset FlushDone", {31'd0, FlushDone}, 32'd0);
        check("reset Error", {31'd0, Error}, 32'd0);
        nReset = 1'b1;
        #1 check("InReady before first clock", {31'd0, InReady}, 32'd0);
        @(posedge Clk);
        #1 check("InReady after first clock", {31'd0, InReady}, 32'd1);
        @(negedge Clk);

        // Sixteen one-bit "1" codewords make one full word.
        for (int i = 0; i < 16; i++) send(5'd0, 5'd0, 2'd0, 1'b0);
        expect_word("t1", 16'hFFFF, 5'd16, 1'b0);
        expect_no_words("t1");

        // Flush of an empty accumulator: pulse only.
        do_flush();
        wait_done("empty flush", 1);
        expect_no_words("empty flush");

        // T0 {1,1} = "01".
        send(5'd0, 5'd1, 2'd1, 1'b0);
        do_flush();
        expect_word("t2", 16'h4000, 5'd2, 1'b1);
        wait_done("t2", 2);
        check("t2 FlushDone follows last word", done_cyc - last_word_cyc, 1);

        // FLC {16,3} = 111111, CDC1 {0,0} = 01; flush issued with the second token.
        send(5'd8, 5'd16, 2'd3, 1'b0);
        send(5'd31, 5'd0, 2'd0, 1'b1);
        expect_word("t3", 16'hFD00, 5'd8, 1'b1);
        wait_done("t3", 3);

        // T1 {3,2}=001001, T2 {0,0}=1111, CDC2 {2,1}=0001101, T2 nC=7 {16,3}=0000000010.
        send(5'd2, 5'd3, 2'd2, 1'b0);
        send(5'd4, 5'd0, 2'd0, 1'b0);
        send(5'd30, 5'd2, 2'd1, 1'b0);
        send(5'd7, 5'd16, 2'd3, 1'b0);
        do_flush();
        expect_word("mix w0", 16'h27C6, 5'd16, 1'b0);
        expect_word("mix w1", 16'h8040, 5'd11, 1'b1);
        wait_done("mix", 4);

        // Illegal tokens set Error and add nothing; CDC1 {1,1} = "1".
        send(5'd31, 5'd5, 2'd0, 1'b0);
        check("illegal cdc1 Error", {31'd0, Error}, 32'd1);
        send(5'd20, 5'd1, 2'd0, 1'b0);
        send(5'd31, 5'd1, 2'd1, 1'b0);
        do_flush();
        expect_word("after illegal", 16'h8000, 5'd1, 1'b1);
        wait_done("after illegal", 5);
        check("Error sticky", {31'd0, Error}, 32'd1);

        // 40 bits under backpressure.
        OutReady = 1'b0;
        send(5'd8, 5'd16, 2'd3, 1'b0);
        send(5'd8, 5'd1, 2'd0, 1'b0);
        send(5'd8, 5'd5, 2'd2, 1'b0);
        send(5'd8, 5'd9, 2'd1, 1'b0);
        send(5'd8, 5'd3, 2'd3, 1'b0);
        send(5'd8, 5'd12, 2'd0, 1'b0);
        InValid      = 1'b1;
        nC           = 5'd0;
        TotalCoeff   = 5'd0;
        TrailingOnes = 2'd0;
        repeat (3) @(negedge Clk);
        #1;
        check("stall InReady", {31'd0, InReady}, 32'd0);
        check("stall OutValid", {31'd0, OutValid}, 32'd1);
        check("stall OutWord", {16'd0, OutWord}, 32'h0000FC04);
        check("stall OutBits", {27'd0, OutBits}, 32'd16);
        check("stall OutLast", {31'd0, OutLast}, 32'd0);
        repeat (2) @(negedge Clk);
        #1;
        check("stall OutWord held", {16'd0, OutWord}, 32'h0000FC04);
        check("stall InReady held", {31'd0, InReady}, 32'd0);
        check("stall no handshake", got_q.size(), 0);
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) send(5'd0, 5'd0, 2'd0, 1'b0);
        do_flush();
        expect_word("bp w0", 16'hFC04, 5'd16, 1'b0);
        expect_word("bp w1", 16'hA12E, 5'd16, 1'b0);
        expect_word("bp w2", 16'hCF00, 5'd8, 1'b1);
        wait_done("bp", 6);
        expect_no_words("bp");

        // Reset while stalled with 20 bits pending.
        OutReady = 1'b0;
        send(5'd8, 5'd16, 2'd3, 1'b0);
        send(5'd8, 5'd1, 2'd0, 1'b0);
        send(5'd8, 5'd5, 2'd2, 1'b0);
        send(5'd0, 5'd1, 2'd1, 1'b0);
        repeat (2) @(negedge Clk);
        #1 check("pending OutValid", {31'd0, OutValid}, 32'd1);
        nReset = 1'b0;
        #1;
        check("mid reset OutValid", {31'd0, OutValid}, 32'd0);
        check("mid reset OutWord", {16'd0, OutWord}, 32'd0);
        check("mid reset OutBits", {27'd0, OutBits}, 32'd0);
        check("mid reset OutLast", {31'd0, OutLast}, 32'd0);
        check("mid reset FlushDone", {31'd0, FlushDone}, 32'd0);
        check("mid reset Error", {31'd0, Error}, 32'd0);
        check("mid reset InReady", {31'd0, InReady}, 32'd0);
        repeat (2) @(negedge Clk);
        OutReady = 1'b1;
        nReset   = 1'b1;
        #1 check("post reset InReady low", {31'd0, InReady}, 32'd0);
        @(posedge Clk);
        #1 check("post reset InReady high", {31'd0, InReady}, 32'd1);
        repeat (20) @(negedge Clk);
        check("post reset no words", got_q.size(), 0);
        check("post reset OutValid", {31'd0, OutValid}, 32'd0);
        check("total flush pulses", done_count, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
